// File: rtl/bus_responder85.sv
`default_nettype none
// ============================================================================
// Module   : bus_responder85
// Purpose  : Peripheral-side responder for the 8085 multiplexed bus. Latches
//            the low address on ALE and decodes a 2^ADDR_BITS-byte register
//            window in I/O or memory space. It stretches hit cycles with
//            WAIT_CYCLES wait states by pulling READY low. Reads are served
//            from an internal register file. Writes commit when WR_ rises.
//            A local port gives the device logic read/write access to the
//            same registers.
// Ports    : clk, rst            clock, async active-high reset
//            ale, ad, a_hi, iom_ bus address phase (ad doubles as write data)
//            rd_, wr_            active-low bus strobes
//            ready               0 = stretch the current bus cycle
//            dout, dout_oe       registered read data and its drive enable
//            loc_addr, loc_we,   local register write port
//            loc_wdata
//            loc_rdata           combinational read of reg[loc_addr]
// Revision : 1.0 - initial release
// ============================================================================
module bus_responder85 #(
  parameter int          DATASIZE    = 8,
  parameter int          ADDR_BITS   = 3,
  parameter logic [15:0] BASE_ADDR   = 16'h0040,
  parameter bit          IO_SPACE    = 1'b1,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ale,
  input  logic [DATASIZE-1:0]  ad,
  input  logic [7:0]           a_hi,
  input  logic                 iom_,
  input  logic                 rd_,
  input  logic                 wr_,
  output logic                 ready,
  output logic [DATASIZE-1:0]  dout,
  output logic                 dout_oe,
  input  logic [ADDR_BITS-1:0] loc_addr,
  input  logic                 loc_we,
  input  logic [DATASIZE-1:0]  loc_wdata,
  output logic [DATASIZE-1:0]  loc_rdata
);

  localparam int         NREGS    = 1 << ADDR_BITS;
  // Wait counter start value; only meaningful when WAIT_CYCLES > 1.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    XFER = 2'd3
  } state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   idx;      // latched register index within window
  logic                   is_read;  // direction of the access in progress
  logic [3:0]             cnt;
  logic [DATASIZE-1:0]    wdata;
  logic [DATASIZE-1:0]    regs [NREGS];

  // --------------------------------------------------------------------------
  // Address decode (evaluated on the cycle ALE is sampled)
  // --------------------------------------------------------------------------
  logic [15:0] bus_addr;
  logic        io_hit;
  logic        mem_hit;
  logic        hit;

  assign bus_addr = {a_hi, ad[7:0]};
  assign io_hit   = iom_ && (bus_addr[7:ADDR_BITS] == BASE_ADDR[7:ADDR_BITS]);
  assign mem_hit  = !iom_ && (bus_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  assign hit      = IO_SPACE ? io_hit : mem_hit;

  // Any strobe low starts an access; once the direction is recorded only the
  // strobe of that direction keeps the access alive.
  logic strobe_any;
  logic strobe_held;
  logic commit;

  assign strobe_any  = !rd_ || !wr_;
  assign strobe_held = is_read ? !rd_ : !wr_;
  assign commit      = (state == XFER) && !is_read && wr_;

  // --------------------------------------------------------------------------
  // Bus cycle state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      is_read <= 1'b0;
      cnt     <= 4'd0;
      wdata   <= '0;
      dout    <= '0;
      dout_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ale) begin
            idx <= ad[ADDR_BITS-1:0];
            if (hit) begin
              state <= ADDR;
            end
          end
        end

        ADDR: begin
          if (ale) begin
            // A fresh address phase before any strobe: decode it again and
            // drop out if the new address is not ours.
            idx <= ad[ADDR_BITS-1:0];
            if (!hit) begin
              state <= IDLE;
            end
          end else if (strobe_any) begin
            is_read <= !rd_;  // read wins if both strobes are low
            cnt     <= CNT_LOAD;
            // Capturing here too keeps wdata valid even if WR_ rises on the
            // very first XFER cycle.
            if (!wr_) begin
              wdata <= ad;
            end
            if (WAIT_CYCLES > 1) begin
              state <= WAIT;
            end else begin
              state <= XFER;
              if (!rd_) begin
                dout    <= regs[idx];
                dout_oe <= 1'b1;
              end
            end
          end
        end

        WAIT: begin
          if (!strobe_held) begin
            // Strobe released before the wait states expired: abort.
            state <= IDLE;
          end else begin
            if (!is_read) begin
              wdata <= ad;
            end
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= XFER;
              if (is_read) begin
                dout    <= regs[idx];
                dout_oe <= 1'b1;
              end
            end
          end
        end

        XFER: begin
          if (is_read) begin
            if (rd_) begin
              dout_oe <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            if (!wr_) begin
              wdata <= ad;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register file: local writes first, so a same-cycle bus commit to the
  // same index overrides them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (loc_we) begin
        regs[loc_addr] <= loc_wdata;
      end
      if (commit) begin
        regs[idx] <= wdata;
      end
    end
  end

  assign loc_rdata = regs[loc_addr];

  // READY falls as soon as a hit access sees its strobe, so the core samples
  // the stretch request in the same T-state.
  assign ready = !(((state == ADDR) && strobe_any && (WAIT_CYCLES > 0)) ||
                   (state == WAIT));

endmodule
`default_nettype wire

// File: tb/tb_bus_responder85.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_responder85
// Purpose  : Self-checking bench for bus_responder85. Four responders with
//            WAIT_CYCLES = 0..3 share one bus and are compared every cycle
//            against a transaction-level timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_responder85;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ale = 1'b0;
  logic       iom_ = 1'b1;
  logic       rd_ = 1'b1;
  logic       wr_ = 1'b1;
  logic [7:0] ad = 8'h00;
  logic [7:0] a_hi = 8'h00;
  logic       loc_we = 1'b0;
  logic [2:0] loc_addr = 3'd0;
  logic [7:0] loc_wdata = 8'h00;

  logic [3:0] rdy;
  logic [3:0] oe;
  logic [7:0] dout_a [4];
  logic [7:0] locr [4];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      bus_responder85 #(
        .DATASIZE(8), .ADDR_BITS(3), .BASE_ADDR(16'h0040),
        .IO_SPACE(1'b1), .WAIT_CYCLES(gi)
      ) u_dut (
        .clk(clk), .rst(rst), .ale(ale), .ad(ad), .a_hi(a_hi), .iom_(iom_),
        .rd_(rd_), .wr_(wr_), .ready(rdy[gi]), .dout(dout_a[gi]),
        .dout_oe(oe[gi]), .loc_addr(loc_addr), .loc_we(loc_we),
        .loc_wdata(loc_wdata), .loc_rdata(locr[gi])
      );
    end
  endgenerate

  // Current transaction descriptor (written by the driver only).
  bit         act = 1'b0;
  int         t_e = 0;      // first edge where the strobe is sampled low
  int         t_l = 0;      // number of edges the strobe is sampled low
  bit         t_read = 1'b0;
  bit         t_hit = 1'b0;
  logic [2:0] t_idx = 3'd0;
  logic [7:0] t_data = 8'h00;

  // Local-port driving: random, or the directed values d_*.
  bit         loc_rand = 1'b0;
  logic       d_we = 1'b0;
  logic [2:0] d_addr = 3'd0;
  logic [7:0] d_wdata = 8'h00;

  int n_chk = 0;
  int n_fail = 0;

  // Model state
  int         cyc = 0;
  logic [7:0] mreg [4][8];
  logic [7:0] snap [4];

  function automatic int need_of(input int wc);
    return (wc > 1) ? wc : 1;
  endfunction

  // Register-file model: a completed read snapshots the register at the edge
  // it enters the data phase; a completed write lands at the edge the strobe
  // is seen high, after any same-edge local write.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 8; j++) mreg[i][j] <= 8'h00;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++) begin
        if (act && t_hit && t_read && t_l >= need_of(i) &&
            cyc + 1 == t_e + need_of(i) - 1)
          snap[i] <= mreg[i][t_idx];
        if (loc_we) mreg[i][loc_addr] <= loc_wdata;
        if (act && t_hit && !t_read && t_l >= need_of(i) &&
            cyc + 1 == t_e + t_l)
          mreg[i][t_idx] <= t_data;
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (loc_rand) begin
      loc_we    = ($urandom_range(0, 3) == 0);
      loc_addr  = 3'($urandom);
      loc_wdata = 8'($urandom);
    end else begin
      loc_we    = d_we;
      loc_addr  = d_addr;
      loc_wdata = d_wdata;
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d] cyc %0d: got %h, want %h", nm, inst, cyc, got, want);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 4; i++) begin
          int  x;
          bit  ex_r;
          bit  ex_oe;
          x     = t_e + need_of(i) - 1;
          ex_r  = 1'b1;
          ex_oe = 1'b0;
          if (act && t_hit) begin
            if (i > 0 && cyc == t_e - 1) ex_r = 1'b0;
            if (cyc >= t_e && cyc < x && cyc < t_e + t_l) ex_r = 1'b0;
            if (t_read && t_l >= need_of(i) && cyc >= x && cyc < t_e + t_l)
              ex_oe = 1'b1;
          end
          chk("ready", i, 32'(rdy[i]), 32'(ex_r));
          chk("dout_oe", i, 32'(oe[i]), 32'(ex_oe));
          if (ex_oe) chk("dout", i, 32'(dout_a[i]), 32'(snap[i]));
          chk("loc_rdata", i, 32'(locr[i]), 32'(mreg[i][loc_addr]));
        end
      end
    end
  endtask

  // One bus access. Entered and left 1 time unit after a rising edge.
  task automatic access(input bit rd, input bit both, input logic [7:0] a,
                        input bit iom, input bit rl, input logic [7:0] a2,
                        input int len, input logic [7:0] data, input bit coll,
                        input int pk, output logic [7:0] sd, output logic so);
    logic [7:0] fa;
    fa   = rl ? a2 : a;
    ale  = 1'b1;
    ad   = a;
    iom_ = iom;
    a_hi = 8'($urandom);
    @(posedge clk); #1;
    if (rl) begin
      ad = a2;
      @(posedge clk); #1;
    end
    ale    = 1'b0;
    ad     = data;
    rd_    = !(rd || both);
    wr_    = !(!rd || both);
    t_e    = cyc + 1;
    t_l    = len;
    t_read = rd || both;
    t_idx  = fa[2:0];
    t_hit  = iom && (fa[7:3] == 5'b01000);
    t_data = data;
    act    = 1'b1;
    repeat (len) begin
      @(posedge clk); #1;
    end
    sd  = dout_a[pk];
    so  = oe[pk];
    rd_ = 1'b1;
    wr_ = 1'b1;
    if (coll) begin
      d_we    = 1'b1;
      d_addr  = fa[2:0];
      d_wdata = 8'h22;
    end
    @(posedge clk); #1;
    d_we = 1'b0;
  endtask

  task automatic local_write(input logic [2:0] a, input logic [7:0] v);
    d_we    = 1'b1;
    d_addr  = a;
    d_wdata = v;
    @(posedge clk); #1;
    d_we = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] sd;
    logic       so;
    fork
      compare_loop();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", -1, 32'(rdy), 32'h0000000F);
    chk("rst_oe", -1, 32'(oe), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_dout", i, 32'(dout_a[i]), 32'h0);
      chk("rst_locr", i, 32'(locr[i]), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Hit write to 0x43
    access(1'b0, 1'b0, 8'h43, 1'b1, 1'b0, 8'h00, 3, 8'hA5, 1'b0, 1, sd, so);
    d_addr = 3'd3;
    @(negedge clk);
    chk("lit_write_reg3", 1, 32'(locr[1]), 32'h000000A5);
    @(posedge clk); #1;

    // Hit read of 0x45 after a local load
    local_write(3'd5, 8'h3C);
    access(1'b1, 1'b0, 8'h45, 1'b1, 1'b0, 8'h00, 4, 8'h00, 1'b0, 2, sd, so);
    chk("lit_read_dout", 2, 32'(sd), 32'h0000003C);
    chk("lit_read_oe", 2, 32'(so), 32'h1);

    // Misses: outside the window, and memory cycle on an I/O responder
    access(1'b0, 1'b0, 8'h48, 1'b1, 1'b0, 8'h00, 3, 8'hFF, 1'b0, 1, sd, so);
    access(1'b0, 1'b0, 8'h43, 1'b0, 1'b0, 8'h00, 3, 8'hFF, 1'b0, 1, sd, so);
    d_addr = 3'd3;
    @(negedge clk);
    chk("lit_miss_reg3", 1, 32'(locr[1]), 32'h000000A5);
    @(posedge clk); #1;

    // Collision: bus 0x11 vs local 0x22 on register 2
    access(1'b0, 1'b0, 8'h42, 1'b1, 1'b0, 8'h00, 3, 8'h11, 1'b1, 1, sd, so);
    d_addr = 3'd2;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("lit_collision", i, 32'(locr[i]), 32'h11);
    @(posedge clk); #1;

    // Aborted read (1-clk strobe) and re-latched read of register 7
    access(1'b1, 1'b0, 8'h45, 1'b1, 1'b0, 8'h00, 1, 8'h00, 1'b0, 3, sd, so);
    chk("lit_abort_oe", 3, 32'(so), 32'h0);
    local_write(3'd7, 8'h77);
    access(1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'h47, 3, 8'h00, 1'b0, 2, sd, so);
    chk("lit_relatch", 2, 32'(sd), 32'h00000077);

    // Reset in the middle of the WAIT_CYCLES=3 wait period (cnt = 1)
    ale  = 1'b1;
    ad   = 8'h45;
    iom_ = 1'b1;
    @(posedge clk); #1;
    ale    = 1'b0;
    rd_    = 1'b0;
    t_e    = cyc + 1;
    t_l    = 100;
    t_read = 1'b1;
    t_idx  = 3'd5;
    t_hit  = 1'b1;
    act    = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    act = 1'b0;
    #1;
    chk("midrst_ready", -1, 32'(rdy), 32'h0000000F);
    chk("midrst_oe", -1, 32'(oe), 32'h0);
    for (int i = 0; i < 4; i++) chk("midrst_locr", i, 32'(locr[i]), 32'h0);
    rd_ = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      d_addr = 3'(a);
      @(posedge clk); #1;
    end

    // Randomized traffic
    loc_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a;
      logic [7:0] a2;
      int         kind;
      a    = ($urandom_range(0, 3) != 0) ? {5'b01000, 3'($urandom)} : 8'($urandom);
      a2   = ($urandom_range(0, 3) != 0) ? {5'b01000, 3'($urandom)} : 8'($urandom);
      kind = $urandom_range(0, 4);
      access(kind < 2 || kind == 4, kind == 4, a, $urandom_range(0, 7) != 0,
             $urandom_range(0, 7) == 0, a2, $urandom_range(1, 5),
             8'($urandom), 1'b0, 0, sd, so);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    loc_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
